// File: rtl/hazard_tracker.sv
// hazard_tracker: forwarding-select and load-use stall unit for an in-order pipeline
module hazard_tracker #(
  parameter int NUM_FWD    = 3,
  parameter int REG_AW     = 5,
  parameter int LOAD_STAGE = 2,
  localparam int SW        = $clog2(NUM_FWD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic              stall,
  output logic [SW-1:0]     fwd_sel1,
  output logic [SW-1:0]     fwd_sel2,
  output logic [31:0]       stall_cnt
);
  logic [NUM_FWD:1]             v_q, v_d, rw_q, rw_d, mr_q, mr_d;
  logic [NUM_FWD:1][REG_AW-1:0] rd_q, rd_d;
  logic [31:0]                  cnt_q, cnt_d;
  logic                         ld1, ld2, load_v;
  // Scan oldest to youngest so the youngest matching producer overwrites the select.
  always_comb begin
    fwd_sel1 = '0;
    fwd_sel2 = '0;
    ld1      = 1'b0;
    ld2      = 1'b0;
    for (int k = NUM_FWD; k >= 1; k--) begin
      if (id_valid && id_use1 && id_rs1 != '0 && v_q[k] && rw_q[k] && rd_q[k] == id_rs1) begin
        fwd_sel1 = SW'(k);
        ld1      = mr_q[k] && k < LOAD_STAGE;
      end
      if (id_valid && id_use2 && id_rs2 != '0 && v_q[k] && rw_q[k] && rd_q[k] == id_rs2) begin
        fwd_sel2 = SW'(k);
        ld2      = mr_q[k] && k < LOAD_STAGE;
      end
    end
  end
  assign stall  = id_valid && !flush && (ld1 || ld2);
  assign load_v = id_valid && !stall && !flush;
  always_comb begin
    v_d   = {v_q[NUM_FWD-1:1], load_v};
    rw_d  = {rw_q[NUM_FWD-1:1], id_regwrite};
    mr_d  = {mr_q[NUM_FWD-1:1], id_memread};
    rd_d  = {rd_q[NUM_FWD-1:1], id_rd};
    cnt_d = (stall && cnt_q != '1) ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q   <= '0;
      rw_q  <= '0;
      mr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      rw_q  <= rw_d;
      mr_q  <= mr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed checks of forwarding, load-use stalls, x0, flush and reset
module tb_hazard_tracker;
  logic        clk, rst, id_valid, id_use1, id_use2, id_regwrite, id_memread, flush;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        stall3, stall4;
  logic [1:0]  sel1_3, sel2_3;
  logic [2:0]  sel1_4, sel2_4;
  logic [31:0] cnt3, cnt4;
  int          n_cmp = 0, n_bad = 0;

  hazard_tracker u3 (.clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .flush(flush), .stall(stall3), .fwd_sel1(sel1_3), .fwd_sel2(sel2_3),
    .stall_cnt(cnt3));
  hazard_tracker #(.NUM_FWD(4), .LOAD_STAGE(3)) u4 (.clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .stall(stall4),
    .fwd_sel1(sel1_4), .fwd_sel2(sel2_4), .stall_cnt(cnt4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic [4:0] rd, input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_use1 = u1; id_rs2 = rs2; id_use2 = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; flush = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_id(1, 5, 1, 5, 1, 6, 1, 0);
    n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall3); end
    n_cmp++; if (sel1_3 !== 2'd0 || sel2_3 !== 2'd0) begin n_bad++; $display("FAIL reset_sel got %0d/%0d want 0/0", sel1_3, sel2_3); end
    n_cmp++; if (cnt3 !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", cnt3); end
    do_reset();
  endtask

  task automatic test_alu_fwd();
    do_reset();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 7, 1, 6, 1, 0);
    n_cmp++; if (sel1_3 !== 2'd1) begin n_bad++; $display("FAIL alu_sel1 got %0d want 1", sel1_3); end
    n_cmp++; if (sel2_3 !== 2'd0) begin n_bad++; $display("FAIL alu_sel2 got %0d want 0", sel2_3); end
    n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("FAIL alu_stall got %0b want 0", stall3); end
    tick();
    set_id(1, 6, 1, 5, 1, 8, 1, 0);
    n_cmp++; if (sel1_3 !== 2'd1 || sel2_3 !== 2'd2) begin n_bad++; $display("FAIL alu_age got %0d/%0d want 1/2", sel1_3, sel2_3); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 1, 1, 0, 0, 5, 1, 1);
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);
    n_cmp++; if (stall3 !== 1'b1 || sel1_3 !== 2'd1) begin n_bad++; $display("FAIL lu_stall got %0b sel %0d want 1 sel 1", stall3, sel1_3); end
    tick();
    n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("FAIL lu_release got %0b want 0", stall3); end
    n_cmp++; if (sel1_3 !== 2'd2 || sel2_3 !== 2'd2) begin n_bad++; $display("FAIL lu_sel got %0d/%0d want 2/2", sel1_3, sel2_3); end
    n_cmp++; if (cnt3 !== 32'd1) begin n_bad++; $display("FAIL lu_cnt got %0d want 1", cnt3); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (cnt3 !== 32'd1) begin n_bad++; $display("FAIL lu_cnt_hold got %0d want 1", cnt3); end
  endtask

  task automatic test_priority();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_id(1, 0, 0, 0, 0, 5, 1, 0);
      tick();
    end
    set_id(1, 5, 1, 0, 0, 9, 1, 0);
    n_cmp++; if (sel1_3 !== 2'd1) begin n_bad++; $display("FAIL prio_123 got %0d want 1", sel1_3); end
    set_id(0, 5, 1, 5, 1, 9, 1, 0);
    n_cmp++; if (sel1_3 !== 2'd0 || sel2_3 !== 2'd0 || stall3 !== 1'b0) begin n_bad++; $display("FAIL prio_idle got %0d/%0d st %0b want 0/0 st 0", sel1_3, sel2_3, stall3); end
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 0);
    tick();
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_id(1, 5, 1, 0, 0, 9, 1, 0);
    n_cmp++; if (sel1_3 !== 2'd2) begin n_bad++; $display("FAIL prio_23 got %0d want 2", sel1_3); end
  endtask

  task automatic test_x0_flush();
    do_reset();
    set_id(1, 1, 1, 2, 1, 0, 1, 1);
    tick();
    set_id(1, 0, 1, 0, 1, 6, 1, 0);
    n_cmp++; if (sel1_3 !== 2'd0 || sel2_3 !== 2'd0 || stall3 !== 1'b0) begin n_bad++; $display("FAIL x0 got %0d/%0d st %0b want 0/0 st 0", sel1_3, sel2_3, stall3); end
    do_reset();
    set_id(1, 1, 1, 0, 0, 5, 1, 1);
    tick();
    set_id(1, 5, 1, 5, 1, 5, 1, 0);
    flush = 1'b1;
    #1;
    n_cmp++; if (stall3 !== 1'b0) begin n_bad++; $display("FAIL flush_stall got %0b want 0", stall3); end
    tick();
    set_id(1, 5, 1, 0, 0, 9, 1, 0);
    n_cmp++; if (sel1_3 !== 2'd2 || stall3 !== 1'b0) begin n_bad++; $display("FAIL flush_entry1 got sel %0d st %0b want sel 2 st 0", sel1_3, stall3); end
    n_cmp++; if (cnt3 !== 32'd0) begin n_bad++; $display("FAIL flush_cnt got %0d want 0", cnt3); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1, 1, 1, 0, 0, 5, 1, 1);
    tick();
    set_id(1, 5, 1, 7, 1, 6, 1, 0);
    n_cmp++; if (stall4 !== 1'b1 || sel1_4 !== 3'd1) begin n_bad++; $display("FAIL b2b_c1 got st %0b sel %0d want st 1 sel 1", stall4, sel1_4); end
    tick();
    n_cmp++; if (stall4 !== 1'b1 || sel1_4 !== 3'd2 || cnt4 !== 32'd1) begin n_bad++; $display("FAIL b2b_c2 got st %0b sel %0d cnt %0d want st 1 sel 2 cnt 1", stall4, sel1_4, cnt4); end
    tick();
    n_cmp++; if (stall4 !== 1'b0 || sel1_4 !== 3'd3 || sel2_4 !== 3'd0) begin n_bad++; $display("FAIL b2b_rel got st %0b sel %0d/%0d want st 0 sel 3/0", stall4, sel1_4, sel2_4); end
    n_cmp++; if (cnt4 !== 32'd2) begin n_bad++; $display("FAIL b2b_cnt got %0d want 2", cnt4); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1, 1, 1, 0, 0, 5, 1, 1);
    tick();
    set_id(1, 5, 1, 0, 0, 6, 1, 0);
    tick();
    n_cmp++; if (stall4 !== 1'b1 || cnt4 !== 32'd1) begin n_bad++; $display("FAIL mid_pre got st %0b cnt %0d want st 1 cnt 1", stall4, cnt4); end
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (stall4 !== 1'b0 || stall3 !== 1'b0) begin n_bad++; $display("FAIL mid_stall got %0b/%0b want 0/0", stall4, stall3); end
    n_cmp++; if (cnt4 !== 32'd0 || cnt3 !== 32'd0) begin n_bad++; $display("FAIL mid_cnt got %0d/%0d want 0/0", cnt4, cnt3); end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (sel1_4 !== 3'd0 || stall4 !== 1'b0) begin n_bad++; $display("FAIL mid_flushed got sel %0d st %0b want sel 0 st 0", sel1_4, stall4); end
  endtask

  initial begin
    rst = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_priority();
    test_x0_flush();
    test_back_to_back();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
